// File: rtl/rv32_regfile_negedge.sv
// rv32_regfile_negedge: RV32I integer register file.
//   x0 hardwired to zero, x1..x31 are 32-bit registers written on the falling
//   clk edge, so the decode stage can read a value in the same cycle it was
//   presented for writing. Two combinational read ports, one write port.
//   Optional macro REGFILE_WR_BYPASS_EN: forward wr_data to a read port that
//   addresses the register being written, for the whole write cycle.

// One storage word: negedge-clocked, enabled, asynchronously cleared.
module rv32_regfile_negedge_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] d,
  output logic [31:0] q
);

  // Capture on the falling edge; reset wins over any pending write.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst)    q <= '0;
    else if (en) q <= d;
  end

endmodule

module rv32_regfile_negedge (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_ena,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [4:0]  rd_addr0,
  output logic [31:0] rd_data0,
  input  logic [4:0]  rd_addr1,
  output logic [31:0] rd_data1
);

  logic [31:0] wr_en_oh;
  logic [31:0] regs [32];
  logic        unused_dec0;

  // Gated 5-to-32 one-hot write decoder.
  always_comb begin
    wr_en_oh = '0;
    if (wr_ena) wr_en_oh[wr_addr] = 1'b1;
  end

  // x0 has no storage; its decoder bit is dropped so writes to it vanish.
  assign unused_dec0 = wr_en_oh[0];
  assign regs[0]     = '0;

  generate
    for (genvar i = 1; i < 32; i++) begin : g_reg
      rv32_regfile_negedge_reg u_reg (
        .clk (clk),
        .rst (rst),
        .en  (wr_en_oh[i]),
        .d   (wr_data),
        .q   (regs[i])
      );
    end
  endgenerate

  // Read port 0: 32:1 mux, optionally overridden by the in-flight write.
  always_comb begin
    rd_data0 = regs[rd_addr0];
`ifdef REGFILE_WR_BYPASS_EN
    if (rst && wr_ena && (wr_addr != 5'd0) && (rd_addr0 == wr_addr))
      rd_data0 = wr_data;
`endif
  end

  // Read port 1: independent copy of port 0.
  always_comb begin
    rd_data1 = regs[rd_addr1];
`ifdef REGFILE_WR_BYPASS_EN
    if (rst && wr_ena && (wr_addr != 5'd0) && (rd_addr1 == wr_addr))
      rd_data1 = wr_data;
`endif
  end

endmodule

// File: tb/tb_rv32_regfile_negedge.sv
// Scoreboard bench for rv32_regfile_negedge: the stimulus process drives
// writes/reads and queues the expected read data from an array model; a
// monitor pops each entry and compares both read ports.
module tb_rv32_regfile_negedge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_ena = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [4:0]  rd_addr0 = '0;
  logic [4:0]  rd_addr1 = '0;
  logic [31:0] rd_data0, rd_data1;

  always #5 clk = ~clk;

  rv32_regfile_negedge dut (
    .clk      (clk),
    .rst      (rst),
    .wr_ena   (wr_ena),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr0 (rd_addr0),
    .rd_data0 (rd_data0),
    .rd_addr1 (rd_addr1),
    .rd_data1 (rd_data1)
  );

  typedef struct {
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] e0;
    logic [31:0] e1;
  } exp_t;

  logic [31:0] model [32];
  exp_t        exp_q [$];
  string       tag_q [$];
  int          errors = 0;
  int          checks = 0;

  // Architectural view: x0 is zero, reset reads zero, optional forwarding.
  function automatic logic [31:0] ref_read(input logic [4:0] a);
    logic [31:0] v;
    if (a == 5'd0 || !rst) return 32'h0;
    v = model[a];
`ifdef REGFILE_WR_BYPASS_EN
    if (wr_ena && wr_addr == a) v = wr_data;
`endif
    return v;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // Present read addresses now and queue what the ports should show.
  task automatic check_now(input logic [4:0] a0, input logic [4:0] a1, input string tag);
    exp_t e;
    rd_addr0 = a0;
    rd_addr1 = a1;
    e.a0 = a0; e.a1 = a1;
    e.e0 = ref_read(a0);
    e.e1 = ref_read(a1);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #2;
  endtask

  // Same, but first move just past the next clk edge.
  task automatic check_read(input logic [4:0] a0, input logic [4:0] a1, input string tag);
    @(clk);
    #1;
    check_now(a0, a1, tag);
  endtask

  // Present a write in the high phase; it commits on the falling edge.
  task automatic do_write(input logic ena, input logic [4:0] addr, input logic [31:0] data);
    @(posedge clk);
    #1;
    wr_ena  = ena;
    wr_addr = addr;
    wr_data = data;
    @(negedge clk);
    if (ena && addr != 5'd0 && rst) model[addr] = data;
    #1;
    wr_ena = 1'b0;
  endtask

  // Monitor: samples both ports 1 time unit after each queued request.
  initial begin
    exp_t  e;
    string t;
    forever begin
      wait (exp_q.size() != 0);
      #1;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (rd_data0 !== e.e0) begin
        errors++;
        $display("FAIL %s port0 addr=%0d got=%h exp=%h", t, e.a0, rd_data0, e.e0);
      end
      checks++;
      if (rd_data1 !== e.e1) begin
        errors++;
        $display("FAIL %s port1 addr=%0d got=%h exp=%h", t, e.a1, rd_data1, e.e1);
      end
    end
  end

  // Stimulus.
  initial begin
    logic [4:0]  ra, rb, wa;
    logic [31:0] wd;
    logic        we;
    clear_model();
    #1 rst = 1'b0;
    #11;
    check_now(5'd5, 5'd0, "reset_state");
    @(posedge clk); #1 rst = 1'b1;

    // basic write/read and hold
    do_write(1'b1, 5'd10, 32'h12345678);
    check_read(5'd10, 5'd11, "basic");
    do_write(1'b0, 5'd10, 32'h0);
    check_read(5'd10, 5'd10, "basic_hold");

    // x0 immutability
    do_write(1'b1, 5'd0, 32'hFFFFFFFF);
    check_read(5'd0, 5'd0, "x0_zero");
    for (int i = 1; i < 32; i++) check_read(5'(i), 5'(i), "x0_others");

    // enable gating
    do_write(1'b1, 5'd7, 32'h1);
    do_write(1'b0, 5'd7, 32'hA5A5A5A5);
    check_read(5'd7, 5'd0, "gating");

    // decoder sweep, dual-port reads
    for (int i = 1; i < 32; i++) do_write(1'b1, 5'(i), 32'(i) * 32'h01010101);
    for (int i = 0; i < 32; i++) check_read(5'(i), 5'(31 - i), "sweep");

    // read-during-write around the falling edge
    @(posedge clk); #1;
    wr_ena = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
    check_now(5'd3, 5'd3, "edge_pre");
    @(negedge clk);
    model[3] = 32'h55;
    #1;
    check_now(5'd3, 5'd0, "edge_post");
    wr_ena = 1'b0;

    // asynchronous reset mid-cycle, writes blocked while held
    do_write(1'b1, 5'd5, 32'hDEADBEEF);
    check_read(5'd5, 5'd5, "preload");
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    check_now(5'd5, 5'd5, "reset_async");
    wr_ena = 1'b1; wr_addr = 5'd9; wr_data = 32'h77;
    for (int i = 0; i < 32; i++) check_read(5'(i), 5'(31 - i), "reset_all");
    wr_ena = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    check_read(5'd9, 5'd5, "reset_release");

    // randomized traffic
    repeat (150) begin
      we = ($urandom_range(0, 3) != 0);
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      do_write(we, wa, wd);
      ra = 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 1) != 0) ? wa : 5'($urandom_range(0, 31));
      check_read(ra, rb, "random");
    end

    // let the monitor drain, bounded
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t limit=200000", $time);
    $fatal(1, "timeout");
  end

endmodule
